// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - byte handshake between the UART register path and the transmitter
interface uart_tx_framer_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  // Producer side: the memory-mapped UART register path.
  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  // Consumer side: the transmitter.
  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - 8N1 UART transmitter with optional input FIFO (UART_TX_FIFO_EN)
module uart_tx_framer #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_framer_if.slave        in_if,
  output logic                   serial_out,
  output logic                   busy
);

  // Bit period in clocks, rounded to nearest.
  localparam int CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_framer: CLKS_PER_BIT must be at least 2");
  end

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_framer: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;

  // Source of the next frame: either the handshake directly or the FIFO head.
  logic             load_avail;
  logic [7:0]       load_byte;
  logic             bit_done;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        take;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = in_if.data_in_valid && !fifo_full;

  assign in_if.data_in_ready = !fifo_full;
  assign load_avail          = !fifo_empty;
  assign load_byte           = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign busy                = (state_q != S_IDLE) || !fifo_empty;

  // FIFO pointer next-state: push from the handshake, pop when the FSM loads a frame.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (take) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // FIFO pointer registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_if.data_in;
    end
  end
`else
  // Ready depends on state only, so valid can never loop back into ready.
  assign in_if.data_in_ready = (state_q == S_IDLE);
  assign load_avail          = in_if.data_in_valid;
  assign load_byte           = in_if.data_in;
  assign busy                = (state_q != S_IDLE);
`endif

  assign bit_done = (cnt_q == CNT_LAST);

  // Frame sequencer next-state, plus the registered line value for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_FIFO_EN
    take    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_avail) begin
          state_d = S_START;
          cnt_d   = '0;
          shift_d = load_byte;
`ifdef UART_TX_FIFO_EN
          take    = 1'b1;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
`ifdef UART_TX_FIFO_EN
          // Chain straight into the next start bit so queued frames are contiguous.
          if (load_avail) begin
            state_d = S_START;
            shift_d = load_byte;
            take    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shift_d[bit_d];
      default: serial_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset abandons any frame and drives the line idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer (honours UART_TX_FIFO_EN)
module tb_uart_tx_framer;
  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 10_000_000;
  localparam int FIFO_DEPTH = 4;
  localparam int N          = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int FRAME      = 10 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_out;
  logic busy;

  uart_tx_framer_if u_if();

  uart_tx_framer #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (u_if),
    .serial_out (serial_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: one frame described by its start edge and byte.
  int         cyc        = 0;
  bit         have_frame = 1'b0;
  int         t_start    = 0;
  logic [7:0] f_byte     = 8'h00;
  logic [7:0] fq[$];
  int         n_acc      = 0;
  int         n_frames   = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic       exp_serial = 1'b1;
  logic       exp_ready  = 1'b1;
  logic       exp_busy   = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_start(input logic [7:0] b);
    prev_start = last_start;
    last_start = cyc;
    t_start    = cyc;
    f_byte     = b;
    have_frame = 1'b1;
    n_frames++;
  endtask

  // Advance the model across one rising edge, then derive the outputs for the following cycle.
  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    int rel;
    int idx;
    int sz;
    if (r) begin
      have_frame = 1'b0;
      fq.delete();
    end else begin
`ifdef UART_TX_FIFO_EN
      sz = fq.size();
      if ((!have_frame || cyc - t_start >= FRAME) && sz > 0) model_start(fq.pop_front());
      if (v && sz < FIFO_DEPTH) begin
        fq.push_back(d);
        n_acc++;
      end
`else
      sz = 0;
      if (v && (!have_frame || cyc - t_start >= FRAME + 1)) begin
        model_start(d);
        n_acc++;
      end
`endif
    end
    rel = cyc - t_start;
    idx = rel / N;
    if (!have_frame || rel >= FRAME) exp_serial = 1'b1;
    else if (idx == 0)               exp_serial = 1'b0;
    else if (idx == 9)               exp_serial = 1'b1;
    else                             exp_serial = f_byte[idx-1];
    exp_busy = have_frame && rel < FRAME;
`ifdef UART_TX_FIFO_EN
    exp_ready = (fq.size() < FIFO_DEPTH);
    if (fq.size() > 0) exp_busy = 1'b1;
`else
    exp_ready = !exp_busy;
`endif
  endtask

  // Model update at each rising edge, comparison at the following falling edge.
  initial begin : model_and_compare
    forever begin
      @(posedge clk);
      cyc++;
      model_edge(rst, u_if.data_in_valid, u_if.data_in);
      @(negedge clk);
      chk1("serial_out", serial_out, exp_serial);
      chk1("data_in_ready", u_if.data_in_ready, exp_ready);
      chk1("busy", busy, exp_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Hold valid until the transfer edge; return just after that edge.
  task automatic send(input logic [7:0] b);
    int base;
    base = n_acc;
    u_if.data_in       = b;
    u_if.data_in_valid = 1'b1;
    for (int i = 0; i < 200 && n_acc == base; i++) step();
    u_if.data_in_valid = 1'b0;
    chki("send_accepted", n_acc - base, 1);
  endtask

  initial begin : stimulus
    logic [9:0] exp_bits;
    int         cur;
    int         j;
    int         off;
    int         base;
    int         base_f;

    u_if.data_in       = 8'hFF;
    u_if.data_in_valid = 1'b1;

    // Held reset with a byte offered: line idle, ready, not busy.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("rst_serial", serial_out, 1'b1);
      chk1("rst_ready", u_if.data_in_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
    end
    step();
    rst                = 1'b0;
    u_if.data_in_valid = 1'b0;
    wait_cycles(15);

    // 0x41: mid-bit samples start,1,0,0,0,0,0,1,0,stop.
    exp_bits = 10'b1010000010;
`ifdef UART_TX_FIFO_EN
    off = 1;
`else
    off = 0;
`endif
    send(8'h41);
    cur = 0;
    for (int k = 0; k < 10; k++) begin
      j = off + k * N + N / 2;
      repeat (j - cur) @(posedge clk);
      @(negedge clk);
      chk1($sformatf("midbit%0d", k), serial_out, exp_bits[k]);
      cur = j;
    end
`ifdef UART_TX_FIFO_EN
    repeat (off + FRAME - 1 - cur) @(posedge clk);
    @(negedge clk);
    chk1("last_stop_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("after_frame_busy", busy, 1'b0);
`else
    repeat (FRAME - 1 - cur) @(posedge clk);
    @(negedge clk);
    chk1("ready_low_T50", u_if.data_in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1("ready_high_T51", u_if.data_in_ready, 1'b1);
`endif
    step();
    wait_cycles(5);

    // Toggling data under a held valid must not disturb the frame in flight.
    send(8'h41);
    base = n_acc;
    u_if.data_in_valid = 1'b1;
    for (int i = 0; i < 80 && n_acc == base; i++) begin
      u_if.data_in = i[0] ? 8'hFF : 8'h00;
      step();
    end
    u_if.data_in_valid = 1'b0;
    chki("toggle_accept", n_acc - base, 1);
`ifndef UART_TX_FIFO_EN
    chki("toggle_gap", last_start - prev_start, FRAME + 1);
`endif
    wait_cycles(FRAME + 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_cycles(3);

    // Back-to-back 0x55 then 0xAA with valid held.
    base   = n_acc;
    base_f = n_frames;
    u_if.data_in       = 8'h55;
    u_if.data_in_valid = 1'b1;
    for (int i = 0; i < 200 && n_acc < base + 2; i++) begin
      step();
      if (n_acc == base + 1) u_if.data_in = 8'hAA;
    end
    u_if.data_in_valid = 1'b0;
    for (int i = 0; i < 200 && n_frames < base_f + 2; i++) step();
    chki("b2b_frames", n_frames - base_f, 2);
`ifdef UART_TX_FIFO_EN
    chki("b2b_gap", last_start - prev_start, FRAME);
`else
    chki("b2b_gap", last_start - prev_start, FRAME + 1);
`endif
    wait_cycles(FRAME + 5);

    // Reset during data bit 3 of 0x00, then a clean 0x5A frame.
    send(8'h00);
    wait_cycles(4 * N);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk1("midframe_rst_serial", serial_out, 1'b1);
    chk1("midframe_rst_ready", u_if.data_in_ready, 1'b1);
    chk1("midframe_rst_busy", busy, 1'b0);
    step();
    send(8'h5A);
    wait_cycles(FRAME + 10);

`ifdef UART_TX_FIFO_EN
    // Four consecutive pushes produce four contiguous frames.
    base   = n_acc;
    base_f = n_frames;
    u_if.data_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.data_in = 8'h31 + 8'(i);
      step();
    end
    u_if.data_in_valid = 1'b0;
    chki("fifo_pushes", n_acc - base, 4);
    repeat (197) @(posedge clk);
    @(negedge clk);
    chk1("fifo_last_stop_busy", busy, 1'b1);
    chki("fifo_frames", n_frames - base_f, 4);
    chki("fifo_contiguous", last_start - prev_start, FRAME);
    @(posedge clk);
    @(negedge clk);
    chk1("fifo_done_busy", busy, 1'b0);
    step();
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      u_if.data_in_valid = ($urandom_range(0, 3) != 0);
      u_if.data_in       = 8'($urandom);
      rst                = ($urandom_range(0, 399) == 0);
      step();
    end
    rst                = 1'b0;
    u_if.data_in_valid = 1'b0;
    wait_cycles(FRAME * (FIFO_DEPTH + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
